alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Handshaked execute unit: the consumer of the 4-bit ALU control code produced by the ALU control decoder.
//  Registers the operands and the control code, then computes the result. Logic/arith ops take 1 cycle.
//  Shifts run iteratively, 1 bit per cycle, to keep the barrel shifter out of the EX path.
//  Sits in EX between the ID/EX register and the EX/MEM register. Stalls the front end through in_ready.
// PARAMETERS
//  WIDTH   32  datapath width in bits (>=8)
//  SHW     5   shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      unit can accept a request
//  alu_ctrl   in   4      control code (see BEHAVIOUR)
//  op_a       in   WIDTH  operand A (rs)
//  op_b       in   WIDTH  operand B (rt / immediate); this is the shifted value for shifts
//  shamt      in   SHW    shift amount
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  ALU result
//  zero       out  1      result == 0
//  overflow   out  1      signed overflow on add/sub (only present with ALU_OVERFLOW_EN)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, overflow=0, shift count=0.
//  Control codes:
//   0000 and    0001 or     0010 add    0110 sub    0111 slt (signed, result 1/0)
//   1010 xor    1011 nor    0011 sll    0100 srl    0101 sra
//   Any other code executes as add.
//  Arithmetic: add/sub wrap modulo 2^WIDTH. slt compares signed A<B.
//  FSM:
//   IDLE: in_ready=1. On in_valid:
//    - non-shift op -> compute into result, go to HOLD (latency 1 cycle).
//    - shift with shamt==0 -> result=op_b, go to HOLD.
//    - shift with shamt>0 -> result=op_b, cnt=shamt, latch op, go to SHIFT.
//   SHIFT: in_ready=0. Each cycle: shift result by 1 (sll: <<1; srl: >>1, zero fill; sra: >>1, sign fill); cnt--.
//    When cnt reaches 1, perform the final shift and go to HOLD. Total latency = shamt+1 cycles.
//   HOLD: out_valid=1, in_ready=0. result, zero and overflow stay stable.
//    On out_ready -> IDLE next cycle, out_valid=0.
//  zero and overflow are registered together with result and update in the same cycle as result.
//  Inputs are sampled only on the in_valid && in_ready edge. Input changes at any other time are ignored.
//  in_valid while busy: not accepted. The requester holds the request (standard valid/ready).
//  Reset asserted mid-SHIFT or mid-HOLD: the operation is abandoned and all outputs return to reset values.
//  One request in flight at a time. No back-to-back issue: min 2 cycles/op (accept, then HOLD).
// CONFIGURATION
//  ALU_OVERFLOW_EN defined:
//   - overflow port exists.
//   - add: overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
//   - sub: overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
//   - overflow is 0 for all other ops. The result still wraps; no trap.
//  ALU_OVERFLOW_EN undefined: overflow port and its logic are absent. Behaviour is otherwise identical.
// TESTING
//  1 add: A=7, B=5, ctrl=0010 -> out_valid 1 cycle after accept, result=12, zero=0.
//  2 sub branch-equal: A=B=0x1234, ctrl=0110 -> result=0, zero=1.
//    Hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0 throughout.
//  3 sra: B=0x80000000, shamt=4, ctrl=0101 -> result=0xF8000000 after 5 cycles.
//    in_ready=0 during SHIFT. Repeat with srl -> 0x08000000.
//  4 shift with shamt=0: ctrl=0011, B=0xA5 -> result=0xA5 after 1 cycle.
//    shamt=31, B=1, sll -> 0x80000000 after 32 cycles.
//  5 slt signed: A=0xFFFFFFFF, B=1 -> result=1. Unknown ctrl=1111 with A=2, B=3 -> result=5.
//  6 rst pulsed mid-SHIFT (shamt=20, cycle 6) -> out_valid=0 and in_ready=1 immediately.
//    The next add completes normally.
//    With ALU_OVERFLOW_EN: 0x7FFFFFFF+1 -> overflow=1, result=0x80000000.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Handshaked EX-stage execute unit. Accepts one ALU operation per
//   request (valid/ready). Logic and arithmetic ops finish in one cycle.
//   Shifts run iteratively, one bit per cycle, so there is no barrel
//   shifter in the path. The result is held until downstream accepts it.
//
// Optional feature macro: ALU_OVERFLOW_EN
//   When defined, the overflow output is present. It reports signed
//   overflow for add and sub.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   in_valid  in   1      request valid
//   in_ready  out  1      unit idle and able to accept a request
//   alu_ctrl  in   4      operation code
//   op_a      in   WIDTH  operand A
//   op_b      in   WIDTH  operand B; this is the value shifted for shifts
//   shamt     in   SHW    shift amount
//   out_valid out  1      result valid; held until out_ready
//   out_ready in   1      downstream accepts the result
//   result    out  WIDTH  ALU result
//   zero      out  1      result == 0
//   overflow  out  1      signed add/sub overflow (ALU_OVERFLOW_EN only)
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Shift kind latched at accept time
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_shop;

  logic             w_accept;
  logic             w_is_shift;
  logic [1:0]       w_shop;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_shifted;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_sum     = op_a + op_b;
  assign w_diff    = op_a - op_b;
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign result    = r_result;
  assign zero      = r_zero;

  // Operation decode and single-cycle result; unknown codes behave as add
  always_comb begin
    w_is_shift = 1'b0;
    w_shop     = SH_SLL;
    w_alu_res  = w_sum;
    case (alu_ctrl)
      4'b0000: w_alu_res = op_a & op_b;
      4'b0001: w_alu_res = op_a | op_b;
      4'b0010: w_alu_res = w_sum;
      4'b0110: w_alu_res = w_diff;
      4'b0111: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1010: w_alu_res = op_a ^ op_b;
      4'b1011: w_alu_res = ~(op_a | op_b);
      4'b0011: begin w_is_shift = 1'b1; w_shop = SH_SLL; w_alu_res = op_b; end
      4'b0100: begin w_is_shift = 1'b1; w_shop = SH_SRL; w_alu_res = op_b; end
      4'b0101: begin w_is_shift = 1'b1; w_shop = SH_SRA; w_alu_res = op_b; end
      default: w_alu_res = w_sum;
    endcase
  end

  // One-bit shift step of the working result
  always_comb begin
    w_shifted = r_result;
    case (r_shop)
      SH_SLL:  w_shifted = {r_result[WIDTH-2:0], 1'b0};
      SH_SRL:  w_shifted = {1'b0, r_result[WIDTH-1:1]};
      SH_SRA:  w_shifted = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
      default: w_shifted = r_result;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic r_overflow;
  logic w_ovf;

  assign overflow = r_overflow;

  // Signed overflow: operand signs vs. result sign, only for add/sub
  always_comb begin
    w_ovf = 1'b0;
    case (alu_ctrl)
      4'b0110: w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
      4'b0000, 4'b0001, 4'b0111, 4'b1010, 4'b1011,
      4'b0011, 4'b0100, 4'b0101: w_ovf = 1'b0;
      default: w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
    endcase
  end

  // Overflow flag register, updated only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_overflow <= w_ovf;
    end else begin
      r_overflow <= r_overflow;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (shamt != {SHW{1'b0}})) begin
            w_next = S_SHIFT;
          end else begin
            w_next = S_HOLD;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        // cnt==1 means this cycle performs the last shift
        if (r_cnt == SHW'(1)) begin
          w_next = S_HOLD;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load on accept, step during SHIFT, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= {WIDTH{1'b0}};
      r_zero   <= 1'b1;
      r_cnt    <= {SHW{1'b0}};
      r_shop   <= SH_SLL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == {WIDTH{1'b0}});
            r_cnt    <= w_is_shift ? shamt : {SHW{1'b0}};
            r_shop   <= w_shop;
          end
        end
        S_SHIFT: begin
          r_result <= w_shifted;
          r_zero   <= (w_shifted == {WIDTH{1'b0}});
          r_cnt    <= r_cnt - SHW'(1);
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: result from the operation's arithmetic meaning
  function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0110: return a - b;
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1010: return a ^ b;
      4'b1011: return ~(a | b);
      4'b0011: return b << s;
      4'b0100: return b >> s;
      4'b0101: return sb >>> s;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] c, input logic [4:0] s);
    if (c == 4'b0011 || c == 4'b0100 || c == 4'b0101) return int'(s) + 1;
    return 1;
  endfunction

`ifdef ALU_OVERFLOW_EN
  // Overflow when the true signed sum/difference does not fit in 32 bits
  function automatic logic ref_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    longint la;
    longint lb;
    longint t;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    if (c == 4'b0110) t = la - lb;
    else if (c == 4'b0000 || c == 4'b0001 || c == 4'b0111 || c == 4'b1010 ||
             c == 4'b1011 || c == 4'b0011 || c == 4'b0100 || c == 4'b0101) return 1'b0;
    else t = la + lb;
    return (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endfunction
`endif

  // Issue one operation, check latency, busy behaviour, result and hold
  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s, input int hold);
    logic [31:0] exp_r;
    int exp_lat;
    int cyc;
    exp_r   = ref_result(c, a, b, s);
    exp_lat = ref_latency(c, s);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    alu_ctrl = c; op_a = a; op_b = b; shamt = s; in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!out_valid && cyc < 64) begin
      chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      // Garbage on the inputs while busy must be ignored
      in_valid = 1'($urandom); op_a = $urandom; op_b = $urandom;
      shamt = 5'($urandom); alu_ctrl = 4'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, exp_lat);
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp_r == 32'd0)});
`ifdef ALU_OVERFLOW_EN
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ref_ovf(c, a, b)});
`endif
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); op_a = $urandom;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, ".hold_result"}, result, exp_r);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drain_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".drain_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [3:0] ctrl_tbl [12];

  initial begin
    ctrl_tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1010,
                 4'b1011, 4'b0011, 4'b0100, 4'b0101, 4'b1111, 4'b1000};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0; shamt = 5'd0;
    #12;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.zero", {31'd0, zero}, 32'd1);
`ifdef ALU_OVERFLOW_EN
    chk("reset.overflow", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_op("add", 4'b0010, 32'd7, 32'd5, 5'd0, 0);
    do_op("sub_eq", 4'b0110, 32'h1234, 32'h1234, 5'd0, 3);
    do_op("sra", 4'b0101, 32'd0, 32'h8000_0000, 5'd4, 1);
    do_op("srl", 4'b0100, 32'd0, 32'h8000_0000, 5'd4, 0);
    do_op("sll0", 4'b0011, 32'd0, 32'h0000_00A5, 5'd0, 0);
    do_op("sll31", 4'b0011, 32'd0, 32'd1, 5'd31, 0);
    do_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    do_op("unk", 4'b1111, 32'd2, 32'd3, 5'd0, 0);

    // Reset during SHIFT abandons the operation
    @(negedge clk);
    alu_ctrl = 4'b0011; op_a = 32'd0; op_b = 32'h0000_0003; shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid.busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid.result", result, 32'd0);
    chk("rst_mid.zero", {31'd0, zero}, 32'd1);
    @(negedge clk); rst = 1'b0;
    do_op("add_after_rst", 4'b0010, 32'd100, 32'd23, 5'd0, 0);
`ifdef ALU_OVERFLOW_EN
    do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
    do_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 5'd0, 0);
`endif

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (n % 5 == 0) ? ra : $urandom;
      do_op("rand", ctrl_tbl[$urandom_range(11, 0)], ra, rb, 5'($urandom), int'($urandom_range(2, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
